// File: rtl/alu_op_sequencer.sv
// Multi-cycle control stage around the ALU: latches a request, enables the ALU
// for the operation's latency, then captures zHI/zLOW into the Z register pair.
module alu_op_sequencer #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] busA,
  input  logic [DATA_W-1:0] busB,
  output logic [DATA_W-1:0] aluA,
  output logic [DATA_W-1:0] aluB,
  output logic [3:0]        aluCtrl,
  output logic              aluEn,
  input  logic [DATA_W-1:0] zHIin,
  input  logic [DATA_W-1:0] zLOWin,
  output logic [DATA_W-1:0] ZHI,
  output logic [DATA_W-1:0] ZLO,
  output logic              busy,
  output logic              done,
  output logic              divZero,
  output logic              badOp
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  function automatic logic [CNT_W-1:0] lat_of(input logic [3:0] code);
    if (code == OP_MUL)      return CNT_W'(MUL_LAT);
    else if (code == OP_DIV) return CNT_W'(DIV_LAT);
    else                     return CNT_W'(1);
  endfunction

  function automatic logic is_bad(input logic [3:0] code);
    return code[3] & code[2];
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= IDLE;
      cnt     <= '0;
      aluA    <= '0;
      aluB    <= '0;
      aluCtrl <= '0;
      ZHI     <= '0;
      ZLO     <= '0;
      divZero <= 1'b0;
      badOp   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aluA    <= busA;
            aluB    <= busB;
            aluCtrl <= op;
            divZero <= 1'b0;
            badOp   <= 1'b0;
            if (is_bad(op)) begin
              badOp <= 1'b1;
              state <= DONE;
            end else if (op == OP_DIV && busB == '0) begin
              // Divide by zero never reaches the ALU; report a zeroed result.
              divZero <= 1'b1;
              ZHI     <= '0;
              ZLO     <= '0;
              state   <= DONE;
            end else begin
              cnt   <= lat_of(op);
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          if (cnt == CNT_W'(1)) begin
            ZHI   <= zHIin;
            ZLO   <= zLOWin;
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign aluEn = (state == EXEC);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: table of single operations plus
// hand-written sequences for start-while-busy, clr mid-op and clr/start collision.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        clr, start;
  logic [3:0]  op;
  logic [31:0] busA, busB, zHIin, zLOWin;
  logic [31:0] aluA, aluB, ZHI, ZLO;
  logic [3:0]  aluCtrl;
  logic        aluEn, busy, done, divZero, badOp;

  int tests = 0;
  int fails = 0;

  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  alu_op_sequencer #(.DATA_W(32), .MUL_LAT(2), .DIV_LAT(1)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .busA(busA), .busB(busB),
    .aluA(aluA), .aluB(aluB), .aluCtrl(aluCtrl), .aluEn(aluEn),
    .zHIin(zHIin), .zLOWin(zLOWin), .ZHI(ZHI), .ZLO(ZLO),
    .busy(busy), .done(done), .divZero(divZero), .badOp(badOp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  op;
    logic [31:0] zh, zl;   // values the ALU model presents on the final EXEC cycle
    int          lat;      // 0 = straight to DONE (bad op / div by zero)
    logic [31:0] ezh, ezl;
    logic        ediv, ebad;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, b, input logic [3:0] o,
                              input logic [31:0] zh, zl, input int lat,
                              input logic [31:0] ezh, ezl, input logic ediv, ebad);
    vec_t v;
    v.a = a; v.b = b; v.op = o; v.zh = zh; v.zl = zl; v.lat = lat;
    v.ezh = ezh; v.ezl = ezl; v.ediv = ediv; v.ebad = ebad;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock; callers always sit at a falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string p;
    p = $sformatf("v%0d", idx);
    start = 1'b1; op = v.op; busA = v.a; busB = v.b;
    zHIin = JUNK; zLOWin = JUNK;
    tick();  // accept edge T0
    start = 1'b0;
    chk({p, ".aluA"}, aluA, v.a);
    chk({p, ".aluB"}, aluB, v.b);
    chk({p, ".aluCtrl"}, {28'd0, aluCtrl}, {28'd0, v.op});
    for (int c = 1; c <= v.lat; c++) begin
      chk({p, $sformatf(".exec%0d.aluEn", c)}, {31'd0, aluEn}, 32'd1);
      chk({p, $sformatf(".exec%0d.busy", c)}, {31'd0, busy}, 32'd1);
      chk({p, $sformatf(".exec%0d.done", c)}, {31'd0, done}, 32'd0);
      zHIin  = (c == v.lat) ? v.zh : JUNK;
      zLOWin = (c == v.lat) ? v.zl : JUNK;
      tick();
    end
    zHIin = JUNK; zLOWin = JUNK;
    chk({p, ".done"}, {31'd0, done}, 32'd1);
    chk({p, ".done.busy"}, {31'd0, busy}, 32'd1);
    chk({p, ".done.aluEn"}, {31'd0, aluEn}, 32'd0);
    chk({p, ".ZHI"}, ZHI, v.ezh);
    chk({p, ".ZLO"}, ZLO, v.ezl);
    chk({p, ".divZero"}, {31'd0, divZero}, {31'd0, v.ediv});
    chk({p, ".badOp"}, {31'd0, badOp}, {31'd0, v.ebad});
    tick();
    chk({p, ".idle.done"}, {31'd0, done}, 32'd0);
    chk({p, ".idle.busy"}, {31'd0, busy}, 32'd0);
    chk({p, ".idle.ZLO"}, ZLO, v.ezl);
  endtask

  vec_t vecs[9];
  int   dones;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mk(32'd5, 32'd7, 4'b0000, 32'd0, 32'd12, 1, 32'd0, 32'd12, 1'b0, 1'b0);
    vecs[1] = mk(32'h0001_0000, 32'h0001_0000, 4'b0010, 32'd1, 32'd0, 2,
                 32'd1, 32'd0, 1'b0, 1'b0);
    vecs[2] = mk(32'd9, 32'd0, 4'b0011, JUNK, JUNK, 0, 32'd0, 32'd0, 1'b1, 1'b0);
    vecs[3] = mk(32'd3, 32'd4, 4'b0000, 32'd0, 32'd7, 1, 32'd0, 32'd7, 1'b0, 1'b0);
    vecs[4] = mk(32'd1, 32'd2, 4'b1101, JUNK, JUNK, 0, 32'd0, 32'd7, 1'b0, 1'b1);
    vecs[5] = mk(32'd100, 32'd7, 4'b0011, 32'd2, 32'd14, 1, 32'd2, 32'd14, 1'b0, 1'b0);
    vecs[6] = mk(32'd8, 32'd8, 4'b1111, JUNK, JUNK, 0, 32'd2, 32'd14, 1'b0, 1'b1);
    vecs[7] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,
                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    vecs[8] = mk(32'h8000_0000, 32'd0, 4'b0011, JUNK, JUNK, 0, 32'd0, 32'd0, 1'b1, 1'b0);

    clr = 1'b1; start = 1'b0; op = 4'd0; busA = '0; busB = '0;
    zHIin = JUNK; zLOWin = JUNK;
    @(negedge clk);
    tick();
    chk("rst.aluA", aluA, 32'd0);
    chk("rst.ZHI", ZHI, 32'd0);
    chk("rst.ZLO", ZLO, 32'd0);
    chk("rst.flags", {26'd0, aluCtrl, divZero, badOp}, 32'd0);
    chk("rst.ctl", {29'd0, aluEn, busy, done}, 32'd0);
    clr = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Start pulses during EXEC and DONE of a multiply are ignored.
    start = 1'b1; op = 4'b0010; busA = 32'd3; busB = 32'd5;
    tick();
    op = 4'b0000; busA = 32'd77; busB = 32'd88;   // start stays high
    dones = 0;
    for (int c = 0; c < 3; c++) begin
      zHIin = (c == 1) ? 32'd0 : JUNK;
      zLOWin = (c == 1) ? 32'd15 : JUNK;
      dones += int'(done);
      chk($sformatf("busy_ign.c%0d.aluCtrl", c), {28'd0, aluCtrl}, 32'd2);
      chk($sformatf("busy_ign.c%0d.aluA", c), aluA, 32'd3);
      tick();
    end
    start = 1'b0;
    dones += int'(done);
    chk("busy_ign.idle", {31'd0, busy}, 32'd0);
    tick();
    dones += int'(done);
    chk("busy_ign.dones", dones, 32'd1);
    chk("busy_ign.ZLO", ZLO, 32'd15);
    chk("busy_ign.aluCtrl_after", {28'd0, aluCtrl}, 32'd2);

    // clr at T0+1 of a multiply aborts it.
    start = 1'b1; op = 4'b0010; busA = 32'h10; busB = 32'h20;
    tick();
    start = 1'b0; clr = 1'b1; zHIin = 32'h1234; zLOWin = 32'h5678;
    tick();
    clr = 1'b0;
    chk("clr_mid.ctl", {29'd0, aluEn, busy, done}, 32'd0);
    chk("clr_mid.aluA", aluA, 32'd0);
    chk("clr_mid.aluB", aluB, 32'd0);
    chk("clr_mid.ZHI", ZHI, 32'd0);
    chk("clr_mid.ZLO", ZLO, 32'd0);
    chk("clr_mid.aluCtrl", {28'd0, aluCtrl}, 32'd0);
    start = 1'b1; op = 4'b0000; busA = 32'd1; busB = 32'd1;
    zHIin = 32'd0; zLOWin = 32'd2;
    tick();
    start = 1'b0;
    chk("clr_mid.reaccept.aluEn", {31'd0, aluEn}, 32'd1);
    tick();
    chk("clr_mid.reaccept.done", {31'd0, done}, 32'd1);
    chk("clr_mid.reaccept.ZLO", ZLO, 32'd2);
    tick();

    // clr and start on the same edge: request dropped.
    clr = 1'b1; start = 1'b1; op = 4'b0000; busA = 32'd9; busB = 32'd9;
    tick();
    clr = 1'b0; start = 1'b0;
    chk("clr_start.busy", {31'd0, busy}, 32'd0);
    chk("clr_start.aluA", aluA, 32'd0);
    tick();
    chk("clr_start.done", {31'd0, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
